// File: rtl/writeback_stage_buffered_if.sv
// Writeback stage bus: MEM-side offer, consumer handshake and retire/head outputs.
// The master side drives instructions in and accepts retirements; the slave is the stage.
interface writeback_stage_buffered_if #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
);
    logic                 flush_i;
    logic                 valid_mem_i;
    logic                 ready_wb_o;
    logic [31:0]          instr_mem_i;
    logic [2:0]           result_src_mem_i;
    logic [XLEN-1:0]      alu_result_mem_i;
    logic [XLEN-1:0]      reduced_data_mem_i;
    logic [XLEN-1:0]      pc_target_mem_i;
    logic [XLEN-1:0]      pc_plus4_mem_i;
    logic [XLEN-1:0]      imm_ext_mem_i;
    logic [XLEN-1:0]      csr_data_mem_i;
    logic [XLEN-1:0]      csr_result_mem_i;
    logic [11:0]          csr_addr_mem_i;
    logic [4:0]           rd_mem_i;
    logic                 reg_write_mem_i;
    logic                 csr_we_mem_i;
    logic                 valid_wb_o;
    logic                 ready_rf_i;
    logic [31:0]          instr_wb_o;
    logic [XLEN-1:0]      result_wb_o;
    logic [XLEN-1:0]      csr_result_wb_o;
    logic [11:0]          csr_addr_wb_o;
    logic [4:0]           rd_wb_o;
    logic                 reg_write_wb_o;
    logic                 csr_we_wb_o;
    logic                 retire_wb_o;
    logic [INSTRET_W-1:0] instret_o;

    modport master (
        output flush_i, valid_mem_i, instr_mem_i, result_src_mem_i, alu_result_mem_i,
               reduced_data_mem_i, pc_target_mem_i, pc_plus4_mem_i, imm_ext_mem_i,
               csr_data_mem_i, csr_result_mem_i, csr_addr_mem_i, rd_mem_i,
               reg_write_mem_i, csr_we_mem_i, ready_rf_i,
        input  ready_wb_o, valid_wb_o, instr_wb_o, result_wb_o, csr_result_wb_o,
               csr_addr_wb_o, rd_wb_o, reg_write_wb_o, csr_we_wb_o, retire_wb_o, instret_o
    );

    modport slave (
        input  flush_i, valid_mem_i, instr_mem_i, result_src_mem_i, alu_result_mem_i,
               reduced_data_mem_i, pc_target_mem_i, pc_plus4_mem_i, imm_ext_mem_i,
               csr_data_mem_i, csr_result_mem_i, csr_addr_mem_i, rd_mem_i,
               reg_write_mem_i, csr_we_mem_i, ready_rf_i,
        output ready_wb_o, valid_wb_o, instr_wb_o, result_wb_o, csr_result_wb_o,
               csr_addr_wb_o, rd_wb_o, reg_write_wb_o, csr_we_wb_o, retire_wb_o, instret_o
    );
endinterface

// File: rtl/writeback_stage_buffered.sv
// In-order retire FIFO between MEM and the register file / CSR port, result select resolved on enqueue.
// Latency: entry pushed on edge N is presented at the head after N (no MEM->WB bypass).
// Backpressure: ready_wb_o = not full, from state only; full with a same-cycle pop still refuses the push.
module writeback_stage_buffered #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter int INSTRET_W = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    writeback_stage_buffered_if.slave wb
);
    localparam logic [2:0] RESULT_ALU      = 3'd0;
    localparam logic [2:0] RESULT_MEM_DATA = 3'd1;
    localparam logic [2:0] RESULT_PCPLUS4  = 3'd2;
    localparam logic [2:0] RESULT_PCTARGET = 3'd3;
    localparam logic [2:0] RESULT_IMM_EXT  = 3'd4;
    localparam logic [2:0] RESULT_CSR      = 3'd5;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] csr_result;
        logic [11:0]     csr_addr;
        logic [4:0]      rd;
        logic            reg_write;
        logic            csr_we;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          push_ent;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            push;
    logic            pop;

    assign wb.ready_wb_o = (count != FULL);
    assign wb.valid_wb_o = (count != '0);
    assign push = wb.valid_mem_i & wb.ready_wb_o & ~wb.flush_i;
    assign pop  = wb.valid_wb_o & wb.ready_rf_i & ~wb.flush_i;

    always_comb begin
        push_ent            = '0;
        push_ent.instr      = wb.instr_mem_i;
        push_ent.csr_result = wb.csr_result_mem_i;
        push_ent.csr_addr   = wb.csr_addr_mem_i;
        push_ent.rd         = wb.rd_mem_i;
        push_ent.reg_write  = wb.reg_write_mem_i;
        push_ent.csr_we     = wb.csr_we_mem_i;
        case (wb.result_src_mem_i)
            RESULT_ALU:      push_ent.result = wb.alu_result_mem_i;
            RESULT_MEM_DATA: push_ent.result = wb.reduced_data_mem_i;
            RESULT_PCPLUS4:  push_ent.result = wb.pc_plus4_mem_i;
            RESULT_PCTARGET: push_ent.result = wb.pc_target_mem_i;
            RESULT_IMM_EXT:  push_ent.result = wb.imm_ext_mem_i;
            RESULT_CSR:      push_ent.result = wb.csr_data_mem_i;
            default:         push_ent.result = '0;
        endcase
    end

    // Storage is deliberately not reset; valid_wb_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wb.instret_o <= '0;
        end else if (wb.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr       <= rd_ptr + PW'(1);
                wb.instret_o <= wb.instret_o + INSTRET_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head               = mem[rd_ptr];
    assign wb.instr_wb_o      = head.instr;
    assign wb.result_wb_o     = head.result;
    assign wb.csr_result_wb_o = head.csr_result;
    assign wb.csr_addr_wb_o   = head.csr_addr;
    assign wb.rd_wb_o         = head.rd;
    assign wb.reg_write_wb_o  = wb.valid_wb_o & head.reg_write & (head.rd != 5'd0);
    assign wb.csr_we_wb_o     = wb.valid_wb_o & head.csr_we;
    assign wb.retire_wb_o     = pop;
endmodule
